// File: rtl/logic_sweep_pkg.sv
// ============================================================================
// Module      : logic_sweep_pkg
// Description : Shared types for the logic sweeper: op-code enum, FSM state
//               type and the op-code to logic-unit select mapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_sweep_pkg;

  localparam int unsigned NUM_OPS = 8;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_NEG  = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The logic unit decodes its select with the op-code bits reversed.
  function automatic logic [2:0] op_to_sel(input logic [2:0] op);
    return {op[0], op[1], op[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_sweep_core.sv
// ============================================================================
// Module      : logic_op_core
// Description : Purely combinational evaluation of one logic op on a and b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_op_core
  import logic_sweep_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result
);

  // Select the requested bitwise function; NEG drops the carry out.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOR:  result = ~a & ~b;
      OP_NAND: result = ~a | ~b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      OP_NEG:  result = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_sweep.sv
// ============================================================================
// Module      : logic_sweep
// Description : Latches an operand pair and streams the result of each
//               enabled logic op (ascending op code) over a valid/ready
//               output, counting completed sweeps.
//               Optional macro LOGIC_SWEEP_MASK_EN enables per-op masking
//               through in_mask; otherwise all eight ops are issued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_sweep
  import logic_sweep_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [7:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic [2:0]       out_sel,
  output logic             out_last,
  output logic [CNT_W-1:0] sweep_cnt
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [7:0]       r_mask;
  logic [7:0]       w_mask_in;
  logic             w_accept;
  logic             w_advance;
  logic             w_finish;
  logic [2:0]       w_calc_op;
  logic [2:0]       w_calc_hi;
  logic [WIDTH-1:0] w_calc_a;
  logic [WIDTH-1:0] w_calc_b;
  logic [WIDTH-1:0] w_calc_res;

`ifdef LOGIC_SWEEP_MASK_EN
  assign w_mask_in = in_mask;
`else
  logic w_unused_mask;
  assign w_mask_in     = 8'hFF;
  assign w_unused_mask = ^in_mask;
`endif

  // Lowest enabled op whose code is at or above 'from' (from may be 8).
  function automatic logic [2:0] lowest_from(input logic [7:0] m, input logic [3:0] from);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= from)) r = 3'(i);
    end
    return r;
  endfunction

  // Highest enabled op; it is the one flagged as last.
  function automatic logic [2:0] highest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign in_ready = (r_state == ST_IDLE);

  // At acceptance the live operands feed the core so the first result is ready next cycle.
  assign w_calc_op = w_accept ? lowest_from(w_mask_in, 4'd0)
                              : lowest_from(r_mask, {1'b0, out_op} + 4'd1);
  assign w_calc_hi = w_accept ? highest(w_mask_in) : highest(r_mask);
  assign w_calc_a  = w_accept ? in_a : r_a;
  assign w_calc_b  = w_accept ? in_b : r_b;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a      (w_calc_a),
    .b      (w_calc_b),
    .op     (op_e'(w_calc_op)),
    .result (w_calc_res)
  );

  // Next-state decode; an empty sweep (nothing valid in RUN) completes at once.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!out_valid) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (out_ready) begin
          if (out_last) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch and registered result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mask    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= 3'd0;
      out_sel   <= 3'd0;
      out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_mask <= w_mask_in;
      end
      if (w_accept || w_advance) begin
        out_valid <= w_accept ? (w_mask_in != 8'h00) : 1'b1;
        out_data  <= w_calc_res;
        out_op    <= w_calc_op;
        out_sel   <= op_to_sel(w_calc_op);
        out_last  <= (w_calc_op == w_calc_hi);
      end else if (w_finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Completed-sweep counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sweep_cnt <= '0;
    else if (w_finish) sweep_cnt <= sweep_cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_logic_sweep.sv
// ============================================================================
// Module      : tb_logic_sweep
// Description : Scoreboard bench for logic_sweep; a second instance with a
//               2-bit counter follows the same stimulus to watch the wrap.
//               Honours LOGIC_SWEEP_MASK_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_sweep;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_a, in_b;
  logic [7:0]       in_mask;
  logic             out_ready;
  logic             in_ready, out_valid, out_last;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op, out_sel;
  logic [CNT_W-1:0] sweep_cnt;
  logic             in_ready2, out_valid2, out_last2;
  logic [WIDTH-1:0] out_data2;
  logic [2:0]       out_op2, out_sel2;
  logic [1:0]       sweep_cnt2;

  logic_sweep #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_sel(out_sel), .out_last(out_last), .sweep_cnt(sweep_cnt)
  );

  logic_sweep #(.WIDTH(WIDTH), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_op(out_op2),
    .out_sel(out_sel2), .out_last(out_last2), .sweep_cnt(sweep_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          op;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;
  bit   cnt_chk = 0;
  int   rdy_mode = 0;
  int   stall_left = 0;

  // Reference behaviour of one op, written from the op definitions.
  function automatic logic [31:0] model_res(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return ~(a | b);
      3:       return ~(a & b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return ~a;
      default: return 32'd0 - a;
    endcase
  endfunction

  // Select code is the op code read with its bits in reverse order.
  function automatic logic [2:0] model_sel(input int op);
    return 3'((op % 2) * 4 + ((op / 2) % 2) * 2 + (op / 4));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares every presented result against the queue head, so a
  // held result is re-checked each stalled cycle; pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_chk) begin
        cnt_chk = 0;
        chk("sweep_cnt", 64'(sweep_cnt), 64'(exp_cnt % 65536));
        chk("sweep_cnt_w2", 64'(sweep_cnt2), 64'(exp_cnt % 4));
        chk("in_ready_after_sweep", 64'(in_ready), 64'd1);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          chk("out_data", 64'(out_data), 64'(q[0].data));
          chk("out_op", 64'(out_op), 64'(q[0].op));
          chk("out_sel", 64'(out_sel), 64'(model_sel(q[0].op)));
          chk("out_last", 64'(out_last), 64'(q[0].last));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) begin
            if (q[0].last) begin
              exp_cnt++;
              cnt_chk = 1;
            end
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Consumer readiness: always, random, or a 5-cycle stall on op 3.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_op == 3'd3 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  // Offer one operand pair; push the expected results, then scramble inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] mask, input bit use_tbl);
    logic [31:0] tbl [8];
    logic [7:0]  eff;
    int          hi;
    int          t;
    tbl = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0FFF_0FFF,
            32'h0FF0_0FF0, 32'hF00F_F00F, 32'h0F0F_0F0F, 32'h0F0F_0F10};
`ifdef LOGIC_SWEEP_MASK_EN
    eff = mask;
`else
    eff = 8'hFF;
`endif
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    hi = -1;
    for (int k = 0; k < 8; k++) if (eff[k]) hi = k;
    for (int k = 0; k < 8; k++) begin
      if (eff[k]) q.push_back('{use_tbl ? tbl[k] : model_res(k, a, b), k, (k == hi)});
    end
    in_valid = 1'b1; in_a = a; in_b = b; in_mask = mask;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_mask = 8'($urandom);
    if (eff == 8'h00) begin
      @(posedge clk); #1;
      exp_cnt++;
      cnt_chk = 1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(q.size() == 0 && in_ready && !cnt_chk) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      fail_now("drain_timeout");
      q.delete();
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mask = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_sweep_cnt", 64'(sweep_cnt), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Abandon the very first sweep by reset while op 4 is presented.
    rdy_mode = 0;
    issue($urandom, $urandom, 8'hFF, 0);
    t = 0;
    while (!(out_valid && out_op == 3'd4) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) fail_now("op4_timeout");
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sweep_cnt", 64'(sweep_cnt), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_idle_valid", 64'(out_valid), 64'd0);
    chk("midrst_cnt_after", 64'(sweep_cnt), 64'd0);

    // Known-answer sweep, then all-zero operands.
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 8'hFF, 1);
    wait_idle();
    issue(32'h0, 32'h0, 8'hFF, 0);
    wait_idle();

    // Consumer stalls for five cycles on op 3.
    rdy_mode = 2; stall_left = 5;
    issue($urandom, $urandom, 8'hFF, 0);
    wait_idle();

`ifdef LOGIC_SWEEP_MASK_EN
    rdy_mode = 0;
    issue($urandom, $urandom, 8'b1000_0010, 0);
    wait_idle();
    issue($urandom, $urandom, 8'h00, 0);
    wait_idle();
`endif

    // Randomised operands, masks and back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) issue($urandom, $urandom, 8'($urandom), 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
